three_sweep_ctrl: RTL and testbench

THREE_SWEEP_CTRL -- requirements
Module: three_sweep_ctrl

---
 rtl/three_sweep_pkg.sv | 14 +
 rtl/three_sweep_cmp.sv | 42 ++++
 rtl/three_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_three_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/three_sweep_pkg.sv
// Shared types and sizes for the three_sweep_ctrl truth-table sweeper.
package three_sweep_pkg;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/three_sweep_cmp.sv
// Sample-time comparator and first-mismatch latch; instantiated by
// three_sweep_ctrl only when THREE_SWEEP_CMP_EN is defined.
module three_sweep_cmp
  import three_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_sample,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_f1,
  input  logic             i_f2,
  input  logic             i_exp_f1,
  input  logic             i_exp_f2,
  output logic             o_err,
  output logic [IDX_W-1:0] o_err_idx
);

  logic             r_err;
  logic [IDX_W-1:0] r_err_idx;
  logic             w_miss;

  assign w_miss = (i_f1 != i_exp_f1) || (i_f2 != i_exp_f2);

  // Once r_err is set the index is frozen, so only the first bad vector is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else if (i_clr) begin
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else if (i_sample && w_miss && !r_err) begin
      r_err     <= 1'b1;
      r_err_idx <= i_idx;
    end
  end

  assign o_err     = r_err;
  assign o_err_idx = r_err_idx;

endmodule

// File: rtl/three_sweep_ctrl.sv
// Sweeps the 16 input vectors of an external `three` block and captures F1/F2
// truth tables. Define THREE_SWEEP_CMP_EN to add golden-table comparison.
module three_sweep_ctrl
  import three_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 1
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                f1_in,
  input  logic                f2_in,
  input  logic [NUM_VEC-1:0]  exp_f1,
  input  logic [NUM_VEC-1:0]  exp_f2,
  output logic                vec_a,
  output logic                vec_b,
  output logic                vec_c,
  output logic                vec_d,
  output logic                busy,
  output logic                done,
  output logic                tab_valid,
  output logic [NUM_VEC-1:0]  f1_tab,
  output logic [NUM_VEC-1:0]  f2_tab,
  output logic                err,
  output logic [IDX_W-1:0]    err_idx
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_tab_valid;
  logic [NUM_VEC-1:0] r_f1_tab;
  logic [NUM_VEC-1:0] r_f2_tab;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tab_valid <= 1'b0;
      // NOTE: the tables are plain flop banks, so they take the async reset too.
      r_f1_tab    <= '0;
      r_f2_tab    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_DRIVE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_tab_valid <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_tab_valid <= 1'b0;
          end else if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          // Abort wins over the capture: an aborted SAMPLE writes nothing.
          if (abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_tab_valid <= 1'b0;
          end else begin
            r_f1_tab[r_idx] <= f1_in;
            r_f2_tab[r_idx] <= f2_in;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_tab_valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {vec_a, vec_b, vec_c, vec_d} = (r_state == ST_IDLE) ? '0 : r_idx;

  assign busy      = r_busy;
  assign done      = r_done;
  assign tab_valid = r_tab_valid;
  assign f1_tab    = r_f1_tab;
  assign f2_tab    = r_f2_tab;

`ifdef THREE_SWEEP_CMP_EN
  logic w_start_acc;
  logic w_sample;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_sample    = (r_state == ST_SAMPLE) && !abort;

  three_sweep_cmp u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_start_acc),
    .i_sample  (w_sample),
    .i_idx     (r_idx),
    .i_f1      (f1_in),
    .i_f2      (f2_in),
    .i_exp_f1  (exp_f1[r_idx]),
    .i_exp_f2  (exp_f2[r_idx]),
    .o_err     (err),
    .o_err_idx (err_idx)
  );
`else
  logic w_unused_exp;
  assign w_unused_exp = ^{exp_f1, exp_f2};
  assign err          = 1'b0;
  assign err_idx      = '0;
`endif

endmodule

// File: tb/tb_three_sweep_ctrl.sv
// Scoreboard bench for three_sweep_ctrl: two instances (SETTLE_CYC 1 and 3)
// share stimulus; a lookup model of `three` answers their vectors.
module tb_three_sweep_ctrl;

  localparam int NI = 2;

  typedef struct {
    int          start_cyc;
    logic [15:0] f1;
    logic [15:0] f2;
    logic        err;
    logic [3:0]  eidx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] exp_f1;
  logic [15:0] exp_f2;
  logic [15:0] tt_f1;
  logic [15:0] tt_f2;

  logic [3:0]  vec    [NI];
  logic        f1_in  [NI];
  logic        f2_in  [NI];
  logic        busy_o [NI];
  logic        done_o [NI];
  logic        tv_o   [NI];
  logic [15:0] f1t    [NI];
  logic [15:0] f2t    [NI];
  logic        err_o  [NI];
  logic [3:0]  eidx_o [NI];

  logic [15:0] mdl_f1 [NI];
  logic [15:0] mdl_f2 [NI];
  exp_t        sb_q   [NI][$];

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behaviour of the attached `three` block: a truth-table lookup.
  assign f1_in[0] = tt_f1[vec[0]];
  assign f2_in[0] = tt_f2[vec[0]];
  assign f1_in[1] = tt_f1[vec[1]];
  assign f2_in[1] = tt_f2[vec[1]];

  three_sweep_ctrl #(.SETTLE_CYC(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f1_in(f1_in[0]), .f2_in(f2_in[0]), .exp_f1(exp_f1), .exp_f2(exp_f2),
    .vec_a(vec[0][3]), .vec_b(vec[0][2]), .vec_c(vec[0][1]), .vec_d(vec[0][0]),
    .busy(busy_o[0]), .done(done_o[0]), .tab_valid(tv_o[0]),
    .f1_tab(f1t[0]), .f2_tab(f2t[0]), .err(err_o[0]), .err_idx(eidx_o[0])
  );

  three_sweep_ctrl #(.SETTLE_CYC(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f1_in(f1_in[1]), .f2_in(f2_in[1]), .exp_f1(exp_f1), .exp_f2(exp_f2),
    .vec_a(vec[1][3]), .vec_b(vec[1][2]), .vec_c(vec[1][1]), .vec_d(vec[1][0]),
    .busy(busy_o[1]), .done(done_o[1]), .tab_valid(tv_o[1]),
    .f1_tab(f1t[1]), .f2_tab(f2t[1]), .err(err_o[1]), .err_idx(eidx_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Vector on the pins n edges after the start-sampling edge.
  function automatic logic [3:0] exp_vec(input int n, input int s);
    if (n < 16 * (s + 1)) return 4'(n / (s + 1));
    if (n == 16 * (s + 1)) return 4'd15;
    return 4'd0;
  endfunction

  function automatic int first_mismatch(input logic [15:0] g1, g2, w1, w2, input int nvec);
    for (int i = 0; i < nvec; i++)
      if (g1[i] !== w1[i] || g2[i] !== w2[i]) return i;
    return -1;
  endfunction

  function automatic logic exp_err(input int fm);
`ifdef THREE_SWEEP_CMP_EN
    return fm >= 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_eidx(input int fm);
`ifdef THREE_SWEEP_CMP_EN
    return (fm >= 0) ? 4'(fm) : 4'd0;
`else
    return 4'd0;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, "_vec"},  vec[k],    0);
      check({tag, "_busy"}, busy_o[k], 0);
      check({tag, "_done"}, done_o[k], 0);
      check({tag, "_tv"},   tv_o[k],   0);
      check({tag, "_f1t"},  f1t[k],    0);
      check({tag, "_f2t"},  f2t[k],    0);
      check({tag, "_err"},  err_o[k],  0);
      check({tag, "_eidx"}, eidx_o[k], 0);
    end
  endtask

  // Scoreboard monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n && done_o[k]) begin
        if (sb_q[k].size() == 0) begin
          check("done_unexpected", done_o[k], 0);
        end else begin
          exp_t e;
          e = sb_q[k].pop_front();
          check("done_latency", cyc - e.start_cyc, 16 * (settle_of(k) + 1) + 1);
          check("done_f1_tab", f1t[k], e.f1);
          check("done_f2_tab", f2t[k], e.f2);
          check("done_err", err_o[k], e.err);
          check("done_err_idx", eidx_o[k], e.eidx);
          check("done_tab_valid", tv_o[k], 1);
          check("done_busy", busy_o[k], 0);
        end
      end
    end
  end

  // One sweep on both instances. abort_at/restart_at/reset_at are edge numbers
  // relative to the start-sampling edge (0 = not used).
  task automatic run_sweep(input logic [15:0] f1, f2, e1, e2,
                           input int abort_at, restart_at, reset_at);
    logic aborted [NI];
    exp_t e;
    int   s, fm, nw;
    logic [15:0] p1, p2;
    @(negedge clk);
    tt_f1 = f1; tt_f2 = f2; exp_f1 = e1; exp_f2 = e2;
    start = 1'b1;
    for (int k = 0; k < NI; k++) begin
      s = settle_of(k);
      aborted[k]  = (abort_at > 0) && (abort_at <= 16 * (s + 1));
      fm          = first_mismatch(f1, f2, e1, e2, 16);
      e.start_cyc = cyc + 1;
      e.f1 = f1; e.f2 = f2;
      e.err = exp_err(fm); e.eidx = exp_eidx(fm);
      if (!aborted[k] && reset_at == 0) sb_q[k].push_back(e);
    end
    for (int n = 0; n <= 67; n++) begin
      @(negedge clk);
      start = (n == restart_at - 1);
      abort = (n == abort_at - 1);
      if (reset_at > 0 && n == reset_at) begin
        start = 1'b0; abort = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        for (int k = 0; k < NI; k++) begin
          sb_q[k].delete();
          mdl_f1[k] = '0; mdl_f2[k] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int k = 0; k < NI; k++) begin
        s = settle_of(k);
        if (aborted[k] && n >= abort_at) begin
          check("abort_busy", busy_o[k], 0);
          check("abort_done", done_o[k], 0);
          check("abort_tv",   tv_o[k],   0);
          check("abort_vec",  vec[k],    0);
          if (n == abort_at) begin
            nw = (abort_at - 1) / (s + 1);
            p1 = mdl_f1[k]; p2 = mdl_f2[k];
            for (int v = 0; v < nw; v++) begin
              p1[v] = f1[v]; p2[v] = f2[v];
            end
            fm = first_mismatch(f1, f2, e1, e2, nw);
            check("abort_f1_tab", f1t[k], p1);
            check("abort_f2_tab", f2t[k], p2);
            check("abort_err", err_o[k], exp_err(fm));
            check("abort_err_idx", eidx_o[k], exp_eidx(fm));
            mdl_f1[k] = p1; mdl_f2[k] = p2;
          end
        end else if (!aborted[k]) begin
          check("sweep_vec",  vec[k],    exp_vec(n, s));
          check("sweep_busy", busy_o[k], n <= 16 * (s + 1));
          check("sweep_done", done_o[k], n == 16 * (s + 1) + 1);
          check("sweep_tv",   tv_o[k],   n > 16 * (s + 1));
        end
      end
    end
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < NI; k++) begin
      if (!aborted[k]) begin
        mdl_f1[k] = f1; mdl_f2[k] = f2;
      end
    end
  endtask

  initial begin
    logic [15:0] r1, r2, m1, m2;
    int a, rs, hi;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    exp_f1 = '0; exp_f2 = '0; tt_f1 = '0; tt_f2 = '0;
    for (int k = 0; k < NI; k++) begin
      mdl_f1[k] = '0; mdl_f2[k] = '0;
    end
    #12 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        check("idle_busy", busy_o[k], 0);
        check("idle_done", done_o[k], 0);
        check("idle_vec",  vec[k],    0);
      end
    end

    // Golden sweep with an ignored second start at edge 4.
    run_sweep(16'hFF5E, 16'hAAFA, 16'hFF5E, 16'hAAFA, 0, 4, 0);
    // Golden tables with mismatching expectations.
    run_sweep(16'hFF5E, 16'hAAFA, 16'hFF5F, 16'hAAF8, 0, 0, 0);
    // Second start ignored, then abort sampled at edge 11.
    run_sweep(16'hFF5E, 16'hAAFA, 16'hFF5E, 16'hAAFA, 11, 4, 0);
    // Async reset mid-sweep, then a full sweep.
    run_sweep(16'hFF5E, 16'hAAFA, 16'hFF5E, 16'hAAFA, 0, 0, 20);
    run_sweep(16'hFF5E, 16'hAAFA, 16'hFF5E, 16'hAAFA, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      r1 = 16'($urandom); r2 = 16'($urandom);
      m1 = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(1 << $urandom_range(0, 15));
      m2 = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(1 << $urandom_range(0, 15));
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 64)) : 0;
      hi = (a > 0) ? a - 1 : 32;
      if (hi > 32) hi = 32;
      rs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, hi)) : 0;
      run_sweep(r1, r2, r1 ^ m1, r2 ^ m2, a, rs, 0);
    end

    for (int k = 0; k < NI; k++) check("scoreboard_drained", sb_q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
